aes_256_ctr: RTL and testbench

Counter-mode front/back end for the pipelined `aes_256` core. It accepts plaintext blocks through a valid/ready handshake and builds the counter block `{nonce, ctr}`. It drives that block and the key into the core and XORs the core's keystream output with the plaintext, delayed to line up with it, to produce ciphertext. It sits directly around `aes_256`: upstream it feeds `state`/`key`, downstream it consumes `out`.

---
 rtl/aes_ctr_pkg.sv | 7 +
 rtl/aes_256_ctr_if.sv | 10 +
 rtl/aes_ctr_delay.sv | 30 +++
 rtl/aes_256_ctr.sv | 83 ++++++++
 tb/tb_aes_256_ctr.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctr_pkg.sv
// aes_ctr_pkg: shared constants and FSM state type for the AES-256 CTR wrapper
package aes_ctr_pkg;
  localparam int AES_LATENCY = 29;
  localparam int NONCE_W = 96;
  localparam int CTR_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, HALT} ctr_state_e;
endpackage

// File: rtl/aes_256_ctr_if.sv
// aes_256_ctr_if: plaintext-in / ciphertext-out stream of aes_256_ctr
interface aes_256_ctr_if;
  logic in_valid;
  logic in_ready;
  logic [127:0] in_data;
  logic out_valid;
  logic [127:0] out_data;
  modport slave (input in_valid, in_data, output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, input in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_ctr_delay.sv
// aes_ctr_delay: LATENCY+1 stage {valid, data} shift register aligning plaintext with the keystream
module aes_ctr_delay
  import aes_ctr_pkg::*;
#(
  parameter int LATENCY = AES_LATENCY,
  parameter int W = 128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic [W-1:0] in_data,
  output logic out_valid,
  output logic [W-1:0] out_data,
  output logic busy
);
  localparam int D = LATENCY + 1;
  logic [D-1:0] v_q;
  logic [W-1:0] d_q [D];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v_q <= '0;
    else v_q <= {v_q[D-2:0], in_valid};
  // Data needs no reset: it is only ever consumed alongside its valid bit.
  always_ff @(posedge clk) begin
    d_q[0] <= in_data;
    for (int i = 1; i < D; i++) d_q[i] <= d_q[i-1];
  end
  assign out_valid = v_q[D-1];
  assign out_data = d_q[D-1];
  assign busy = |v_q;
endmodule

// File: rtl/aes_256_ctr.sv
// aes_256_ctr: CTR-mode wrapper around a pipelined aes_256 core; AES_CTR_ZEROIZE_EN clears key/nonce on exhaustion
module aes_256_ctr
  import aes_ctr_pkg::*;
#(
  parameter int LATENCY = AES_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [255:0] key_in,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0] ctr_init,
  aes_256_ctr_if.slave s,
  output logic busy,
  output logic [127:0] aes_state,
  output logic [255:0] aes_key,
  input  logic [127:0] aes_out
);
  ctr_state_e state_q, state_d;
  logic [255:0] key_q, key_d, aes_key_q, aes_key_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [127:0] aes_state_q, aes_state_d, out_data_q, out_data_d, dly_data;
  logic in_ready_q, out_valid_q, dly_valid, accept, last;
  assign accept = s.in_valid && in_ready_q;
  assign last = accept && ctr_q == '1;
  aes_ctr_delay #(.LATENCY(LATENCY)) u_dly (
    .clk,
    .rst_n,
    .in_valid(accept),
    .in_data(s.in_data),
    .out_valid(dly_valid),
    .out_data(dly_data),
    .busy
  );
  // An accept coinciding with start still uses the old context; the new one applies afterwards.
  always_comb begin
    state_d = start ? RUN : last ? HALT : state_q;
    key_d = start ? key_in : key_q;
    nonce_d = start ? nonce : nonce_q;
    ctr_d = start ? ctr_init : accept ? ctr_q + CTR_W'(1) : ctr_q;
    aes_state_d = accept ? {nonce_q, ctr_q} : aes_state_q;
    aes_key_d = accept ? key_q : aes_key_q;
    out_data_d = dly_valid ? aes_out ^ dly_data : out_data_q;
`ifdef AES_CTR_ZEROIZE_EN
    if (last && !start) begin
      key_d = '0;
      nonce_d = '0;
    end
    if (state_q != RUN && !busy) begin
      aes_state_d = '0;
      aes_key_d = '0;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      key_q <= '0;
      nonce_q <= '0;
      ctr_q <= '0;
      aes_state_q <= '0;
      aes_key_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      nonce_q <= nonce_d;
      ctr_q <= ctr_d;
      aes_state_q <= aes_state_d;
      aes_key_q <= aes_key_d;
      out_data_q <= out_data_d;
      out_valid_q <= dly_valid;
      in_ready_q <= state_d == RUN;
    end
  assign s.in_ready = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.out_data = out_data_q;
  assign aes_state = aes_state_q;
  assign aes_key = aes_key_q;
endmodule

// File: tb/tb_aes_256_ctr.sv
// tb_aes_256_ctr: directed bench with a behavioural pipelined AES-256 core and an output scoreboard
module tb_aes_256_ctr;
  import aes_ctr_pkg::*;
  localparam logic [255:0] KA = 256'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe;
  localparam logic [255:0] KB = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0] NA = 96'h3243f6a8885a308d313198a2;
  localparam logic [95:0] NB = 96'h00112233445566778899aabb;
  localparam logic [31:0] CA = 32'he0370734;
  localparam logic [31:0] CB = 32'hccddeeff;
  localparam logic [127:0] VA = 128'h1a6e6c2c662e7da6501ffb62bc9e93f3;
  localparam logic [127:0] VB = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk, rst_n, start, busy;
  logic [255:0] key_in, aes_key;
  logic [95:0] nonce;
  logic [31:0] ctr_init;
  logic [127:0] aes_state, aes_out;
  aes_256_ctr_if sif ();

  aes_256_ctr dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .key_in(key_in),
    .nonce(nonce),
    .ctr_init(ctr_init),
    .s(sif.slave),
    .busy(busy),
    .aes_state(aes_state),
    .aes_key(aes_key),
    .aes_out(aes_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference AES-256 encryption; S-box derived from GF(2^8) inverse plus affine map.
  logic [7:0] sbox [256];
  bit sbox_ok;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] k);
    logic [31:0] w [60];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) tmp = subw(tmp);
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[4*((i/4 + i%4) % 4) + i%4]];
      if (rnd < 14)
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c];
          a1 = t[4*c+1];
          a2 = t[4*c+2];
          a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // Core model: samples state/key each edge, result visible AES_LATENCY edges after sampling.
  logic [127:0] core_in;
  logic [127:0] pipe [AES_LATENCY];
  always @(aes_state or aes_key or sbox_ok) core_in = sbox_ok ? aes_enc(aes_state, aes_key) : 128'h0;
  always @(posedge clk) begin
    pipe[0] <= core_in;
    for (int i = 1; i < AES_LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign aes_out = pipe[AES_LATENCY-1];

  typedef struct packed {int cyc; logic [127:0] d;} exp_t;
  exp_t sb [$];
  int cyc, total, bad, n_out, last_acc;
  logic [255:0] m_key;
  logic [95:0] m_nonce;
  logic [31:0] m_ctr;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accept with the bench's own context/counter model, pop on out_valid.
  initial begin
    exp_t e;
    n_out = 0;
    last_acc = 0;
    m_key = '0;
    m_nonce = '0;
    m_ctr = '0;
    forever begin
      @(negedge clk);
      if (sif.in_valid && sif.in_ready) begin
        sb.push_back('{cyc + 1, aes_enc({m_nonce, m_ctr}, m_key) ^ sif.in_data});
        m_ctr = m_ctr + 32'd1;
        last_acc = cyc + 1;
      end
      if (start) begin
        m_key = key_in;
        m_nonce = nonce;
        m_ctr = ctr_init;
      end
      if (sif.out_valid) begin
        n_out++;
        chk("out_expected", 256'(sb.size() != 0), 256'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", 256'(sif.out_data), 256'(e.d));
          chk("out_cycle", 256'(cyc), 256'(e.cyc + AES_LATENCY + 1));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    key_in = k;
    nonce = n;
    ctr_init = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 256'(n < 200), 256'(1));
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 256'(sif.in_ready), 256'(0));
    chk({tag, "_out_valid"}, 256'(sif.out_valid), 256'(0));
    chk({tag, "_out_data"}, 256'(sif.out_data), 256'(0));
    chk({tag, "_aes_state"}, 256'(aes_state), 256'(0));
    chk({tag, "_aes_key"}, aes_key, 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
  endtask

  initial begin
    int n, n0;
    logic [7:0] inv;
    rst_n = 1'b0;
    start = 1'b0;
    key_in = '0;
    nonce = '0;
    ctr_init = '0;
    sif.in_valid = 1'b0;
    sif.in_data = '0;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rl(inv) ^ rl(rl(inv)) ^ rl(rl(rl(inv))) ^ rl(rl(rl(rl(inv)))) ^ 8'h63;
    end
    sbox_ok = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk_reset("reset");
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk_reset("idle");
    chk("idle_no_out", 256'(n_out), 256'(0));

    // Vector B, zero plaintext, then its ciphertext fed back
    tick();
    go(KB, NB, CB);
    @(negedge clk);
    chk("run_in_ready", 256'(sif.in_ready), 256'(1));
    tick();
    sif.in_valid = 1'b1;
    sif.in_data = '0;
    tick();
    sif.in_valid = 1'b0;
    drain("drain_vb");
    chk("vb_data", 256'(sif.out_data), 256'(VB));
    go(KB, NB, CB);
    sif.in_valid = 1'b1;
    sif.in_data = VB;
    tick();
    sif.in_valid = 1'b0;
    drain("drain_vb_inv");
    chk("vb_inv_data", 256'(sif.out_data), 256'(0));

    // Back-to-back contexts, start coinciding with the first accept
    go(KA, NA, CA);
    sif.in_valid = 1'b1;
    sif.in_data = '0;
    key_in = KB;
    nonce = NB;
    ctr_init = CB;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    sif.in_valid = 1'b0;
    n = 0;
    while (!sif.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_seen", 256'(n < 40), 256'(1));
    chk("b2b_first", 256'(sif.out_data), 256'(VA));
    @(negedge clk);
    chk("b2b_second_valid", 256'(sif.out_valid), 256'(1));
    chk("b2b_second", 256'(sif.out_data), 256'(VB));
    tick();
    drain("drain_b2b");

    // Counter exhaustion with in_valid held high
    go(KB, NB, 32'hfffffffe);
    sif.in_valid = 1'b1;
    sif.in_data = 128'h0123456789abcdeffedcba9876543210;
    @(negedge clk);
    chk("ex_ready0", 256'(sif.in_ready), 256'(1));
    @(negedge clk);
    chk("ex_ctr0", 256'(aes_state[31:0]), 256'(32'hfffffffe));
    chk("ex_ready1", 256'(sif.in_ready), 256'(1));
    @(negedge clk);
    chk("ex_ctr1", 256'(aes_state[31:0]), 256'(32'hffffffff));
    chk("ex_halt", 256'(sif.in_ready), 256'(0));
    n0 = n_out;
    repeat (5) @(negedge clk);
    chk("ex_hold", 256'(aes_state[31:0]), 256'(32'hffffffff));
    chk("ex_halt_stay", 256'(sif.in_ready), 256'(0));
    tick();
    sif.in_valid = 1'b0;
    drain("drain_ex");
    chk("ex_outs", 256'(n_out - n0), 256'(2));
    @(negedge clk);
`ifdef AES_CTR_ZEROIZE_EN
    chk("ex_zero_key", aes_key, 256'(0));
    chk("ex_zero_state", 256'(aes_state), 256'(0));
`else
    chk("ex_keep_key", aes_key, KB);
    chk("ex_keep_state", 256'(aes_state), 256'({NB, 32'hffffffff}));
`endif

    // Random input gaps
    tick();
    go(KA, NA, 32'h0);
    for (int i = 0; i < 40; i++) begin
      sif.in_valid = 1'($urandom_range(0, 1));
      sif.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    sif.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    chk("gap_busy_fall", 256'(cyc), 256'(last_acc + AES_LATENCY + 1));
    tick();
    drain("drain_gap");

    // Reset mid-flight
    go(KB, NB, CB);
    sif.in_valid = 1'b1;
    repeat (3) tick();
    sif.in_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    sb.delete();
    n0 = n_out;
    @(negedge clk);
    chk_reset("midrst");
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    @(negedge clk);
    chk("midrst_no_out", 256'(n_out - n0), 256'(0));
    chk_reset("midrst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
